// File: rtl/mmio_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package mmio_pkg;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   localparam logic [2:0] UART_TXDATA_OFS = 3'h0;
   localparam logic [2:0] UART_STATUS_OFS = 3'h4;

   localparam int unsigned ST_FULL    = 0;
   localparam int unsigned ST_EMPTY   = 1;
   localparam int unsigned ST_BUSY    = 2;
   localparam int unsigned ST_OVF     = 3;
   localparam int unsigned ST_CNT_LSB = 4;
   localparam int unsigned ST_CNT_W   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a TX FIFO drained by a serialiser FSM.
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] write_data,
   output logic        sel,
   output logic [31:0] rd_data,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

   uart_state_e        state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_d;
   logic               overflow_q;

   logic               wr_txdata_c;
   logic               wr_status_c;
   logic               pop_c;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [7:0]         fifo_rdata;
   logic [31:0]        status_c;
   logic               unused_bits;

   assign sel         = (data_addr[31:3] == BASE_ADDR[31:3]);
   assign wr_txdata_c = sel & mem_write & (data_addr[2] == UART_TXDATA_OFS[2]);
   assign wr_status_c = sel & mem_write & (data_addr[2] == UART_STATUS_OFS[2]);
   assign busy        = (state_q != UART_IDLE) | ~fifo_empty;
   assign unused_bits = ^{data_addr[1:0], write_data[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata_c),
      .pop   (pop_c),
      .wdata (write_data[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Status word and read mux.
   always_comb begin
      status_c                            = '0;
      status_c[ST_FULL]                   = fifo_full;
      status_c[ST_EMPTY]                  = fifo_empty;
      status_c[ST_BUSY]                   = busy;
      status_c[ST_OVF]                    = overflow_q;
      status_c[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
   end

   assign rd_data = (sel && (data_addr[2] == UART_STATUS_OFS[2])) ? status_c : '0;

   // Sticky overflow: a rejected push beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (wr_txdata_c && fifo_full && !pop_c) begin
         overflow_q <= 1'b1;
      end else if (wr_status_c && write_data[ST_OVF]) begin
         overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= UART_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx      <= tx_d;
      end
   end

   // tx_d is the line level for the coming cycle, so every transition also sets it.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx;
      pop_c   = 1'b0;

      unique case (state_q)
         UART_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               shift_d = fifo_rdata;
               timer_d = TIMER_W'(CLKS_PER_BIT - 1);
               state_d = UART_START;
               tx_d    = 1'b0;
            end
         end
         UART_START: begin
            if (timer_q == '0) begin
               state_d = UART_DATA;
               bit_d   = '0;
               timer_d = TIMER_W'(CLKS_PER_BIT - 1);
               tx_d    = shift_q[0];
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         UART_DATA: begin
            if (timer_q == '0) begin
               timer_d = TIMER_W'(CLKS_PER_BIT - 1);
               if (bit_q == 3'd7) begin
                  state_d = UART_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         UART_STOP: begin
            if (timer_q == '0) begin
               if (!fifo_empty) begin
                  pop_c   = 1'b1;
                  shift_d = fifo_rdata;
                  timer_d = TIMER_W'(CLKS_PER_BIT - 1);
                  state_d = UART_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = UART_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = UART_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a line receiver that logs decoded bytes.
module tb_mmio_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic [31:0] data_addr;
   logic [31:0] write_data;
   logic        sel;
   logic [31:0] rd_data;
   logic        tx;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] rx_q[$];
   int         frame_err = 0;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_write  (mem_write),
      .data_addr  (data_addr),
      .write_data (write_data),
      .sel        (sel),
      .rd_data    (rd_data),
      .tx         (tx),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Receiver: samples mid-bit, four negedges per bit.
   initial begin
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
            repeat (2) @(negedge clk);
            if (tx !== 1'b0) frame_err++;
            for (int k = 0; k < 8; k++) begin
               repeat (4) @(negedge clk);
               b[k] = tx;
            end
            repeat (4) @(negedge clk);
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(b);
            @(negedge clk);
         end
         prev = tx;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      data_addr  = a;
      write_data = d;
      mem_write  = 1'b1;
      @(negedge clk);
      mem_write  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, n);
      end
      @(negedge clk);
   endtask

   task automatic wait_rx(input string name, input int want);
      int n;
      n = 0;
      while (rx_q.size() < want && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rx_q.size() < want) begin
         errors++;
         $display("FAIL %s_rx_timeout: got %0d bytes, want %0d", name, rx_q.size(), want);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      mem_write  = 1'b0;
      data_addr  = '0;
      write_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      data_addr = BASE + 32'd4;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (rd_data !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h want 00000002", rd_data); end
      checks++;
      if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b want 1", sel); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      logic [39:0] exp;
      logic [7:0]  d;
      d   = 8'hA5;
      exp = '0;
      for (int i = 0; i < 40; i++) begin
         if (i < 4)       exp[i] = 1'b0;
         else if (i < 36) exp[i] = d[(i - 4) / 4];
         else             exp[i] = 1'b1;
      end
      wait_idle("single");
      store(BASE, 32'h0000_00A5);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_pre_pop: tx=%b busy=%b want tx=1 busy=1", tx, busy);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== exp[i]) begin
            errors++;
            $display("FAIL single_tx[%0d]: got %b want %b", i, tx, exp[i]);
         end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b want 1", busy); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_end: busy=%b tx=%b want busy=0 tx=1", busy, tx);
      end
   endtask

   task automatic test_overflow();
      wait_idle("ovf");
      rx_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         data_addr  = BASE;
         write_data = 32'(i + 1);
         mem_write  = 1'b1;
      end
      @(negedge clk);
      mem_write = 1'b0;
      data_addr = BASE + 32'd4;
      #1;
      checks++;
      if (rd_data !== 32'h0000_004D) begin errors++; $display("FAIL ovf_status: got %h want 0000004d", rd_data); end
      store(BASE + 32'd4, 32'h0000_0008);
      data_addr = BASE + 32'd4;
      #1;
      checks++;
      if (rd_data !== 32'h0000_0045) begin errors++; $display("FAIL ovf_clear: got %h want 00000045", rd_data); end
      wait_rx("ovf", 5);
      wait_idle("ovf_drain");
      checks++;
      if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d bytes want 5", rx_q.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i < rx_q.size() && rx_q[i] !== 8'(i + 1)) begin
            errors++;
            $display("FAIL ovf_byte[%0d]: got %h want %h", i, rx_q[i], 8'(i + 1));
         end
      end
      checks++;
      if (frame_err != 0) begin errors++; $display("FAIL ovf_framing: got %0d errors want 0", frame_err); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] bytes [6];
      bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
      wait_idle("fullpp");
      rx_q.delete();
      for (int j = 0; j < 42; j++) begin
         @(negedge clk);
         if (j < 5 || j == 41) begin
            data_addr  = BASE;
            write_data = {24'h0, bytes[(j == 41) ? 5 : j]};
            mem_write  = 1'b1;
         end else begin
            mem_write = 1'b0;
            if (j == 40) begin
               data_addr = BASE + 32'd4;
               #1;
               checks++;
               if (rd_data !== 32'h0000_0045) begin errors++; $display("FAIL fullpp_before: got %h want 00000045", rd_data); end
            end
         end
      end
      @(negedge clk);
      mem_write = 1'b0;
      data_addr = BASE + 32'd4;
      #1;
      checks++;
      if (rd_data !== 32'h0000_0045) begin errors++; $display("FAIL fullpp_after: got %h want 00000045", rd_data); end
      wait_rx("fullpp", 6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i < rx_q.size() && rx_q[i] !== bytes[i]) begin
            errors++;
            $display("FAIL fullpp_byte[%0d]: got %h want %h", i, rx_q[i], bytes[i]);
         end
      end
      wait_idle("fullpp_drain");
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      wait_idle("rstmid");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         data_addr  = BASE;
         write_data = 32'h0000_00C3 + 32'(i);
         mem_write  = 1'b1;
      end
      @(negedge clk);
      mem_write = 1'b0;
      repeat (15) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
      reset = 1'b0;
      @(negedge clk);
      data_addr = BASE + 32'd4;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
      checks++;
      if (rd_data !== 32'h0000_0002) begin errors++; $display("FAIL rstmid_status: got %h want 00000002", rd_data); end
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
      rx_q.delete();
   endtask

   task automatic test_out_of_window();
      @(negedge clk);
      data_addr  = BASE + 32'd8;
      write_data = 32'h0000_0055;
      mem_write  = 1'b1;
      #1;
      checks++;
      if (sel !== 1'b0 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL oow_store: sel=%b rd_data=%h want sel=0 rd_data=0", sel, rd_data);
      end
      @(negedge clk);
      mem_write = 1'b0;
      data_addr = BASE + 32'd7;
      #1;
      checks++;
      if (rd_data !== 32'h0000_0002) begin errors++; $display("FAIL oow_status: got %h want 00000002", rd_data); end
      data_addr = BASE;
      #1;
      checks++;
      if (sel !== 1'b1 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL oow_load_txdata: sel=%b rd_data=%h want sel=1 rd_data=0", sel, rd_data);
      end
      data_addr = BASE + 32'd12;
      #1;
      checks++;
      if (sel !== 1'b0 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL oow_load_outside: sel=%b rd_data=%h want sel=0 rd_data=0", sel, rd_data);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL oow_quiet: busy=%b tx=%b want busy=0 tx=1", busy, tx);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_frame();
      test_out_of_window();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
